seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGIT_CYCLES, default 50000: clk cycles per digit slot.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500: anti-ghost blank cycles at the start of each slot; legal range is 1 <= BLANK_CYCLES < DIGIT_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: scan enable.
REQ-006 The block SHALL have port lz_blank, input, 1 bit: leading-zero blanking enable.
REQ-007 The block SHALL have ports out0, out1, out2, out3, inputs, 8 bits each: active-low segment codes, bit7 = DP, where out0 is the ones digit and out3 the thousands digit.
REQ-008 The block SHALL have port seg, output, 8 bits: shared active-low segment bus.
REQ-009 The block SHALL have port an, output, 4 bits: active-low digit anodes, where an[i] selects outi.
REQ-010 The block SHALL have port digit_idx, output, 2 bits: the index of the current slot.
REQ-011 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of digit 3's slot.

Function
REQ-012 The block SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-013 The block SHALL implement states IDLE, BLANK, and SHOW.
  - IDLE: an=4'b1111, seg=8'hFF, digit_idx=0.
  - BLANK: an=4'b1111, seg=8'hFF, held for BLANK_CYCLES cycles.
  - SHOW: an has only bit digit_idx low; seg = displayed code; held for DIGIT_CYCLES-BLANK_CYCLES cycles.
REQ-014 The block SHALL keep one slot counter that spans BLANK followed by SHOW, totalling exactly DIGIT_CYCLES cycles per digit.
REQ-015 The block SHALL transition IDLE -> BLANK, with digit_idx=0, on the clk edge that samples enable=1.
REQ-016 At the end of each SHOW, the block SHALL go to BLANK with digit_idx incremented mod 4; digit 3 wraps to 0 with no gap.
REQ-017 The block SHALL capture out0..out3 and lz_blank into shadow registers on the first BLANK cycle of digit 0, so that a frame never mixes values; input changes mid-frame take effect next frame.
REQ-018 The block SHALL compute the displayed code as follows.
  - Digit 0: always its shadow code.
  - Digit 3: 8'hFF if lz_blank is set and shadow3==8'hC0 (glyph "0").
  - Digit 2: 8'hFF if lz_blank is set and shadow3 and shadow2 are both 8'hC0.
  - Digit 1: 8'hFF if lz_blank is set and shadow3, shadow2 and shadow1 are all 8'hC0.
  - Otherwise: the shadow code unchanged, DP included.
REQ-019 The block SHALL assert frame_done for exactly the last SHOW cycle of digit 3.
REQ-020 On enable=0, sampled in any state, the next cycle SHALL be IDLE with the counter cleared and frame_done=0; a partial frame produces no frame_done.
REQ-021 If enable drops and rises on consecutive cycles, the block SHALL pass through IDLE for at least one cycle, then restart at digit 0 with a new shadow capture.
REQ-022 At any clock, at most one an bit SHALL be low, and an SHALL be all-high in BLANK and IDLE.
REQ-023 The block SHALL size the slot counter as clog2(DIGIT_CYCLES) bits, and it SHALL never exceed DIGIT_CYCLES-1.

Reset
REQ-024 While rst_n=0, the block SHALL asynchronously force state=IDLE, counter=0, digit_idx=0, an=4'b1111, seg=8'hFF, frame_done=0, and all shadows=8'hFF.
REQ-025 On rst_n rising with enable=1, the block SHALL enter BLANK on the first clk edge after release.
REQ-026 Reset asserted mid-SHOW SHALL blank the display immediately, without waiting for a clock edge.

Verification (DIGIT_CYCLES=8, BLANK_CYCLES=2)
REQ-027 The bench SHALL cover: out0..3 = C0, F9, A4, B0, lz_blank=0, enable held for 64 cycles -> for each digit i, 2 blank cycles then 6 cycles of an=~(1<<i) with seg=outi; frame_done pulses at cycles 32 and 64 after the first BLANK.
REQ-028 The bench SHALL cover: out3=C0, out2=C0, out1=F9, out0=C0, lz_blank=1 -> digits 3 and 2 show seg=FF, digit 1 shows F9, digit 0 shows C0.
REQ-029 The bench SHALL cover: all four digits = C0, lz_blank=1 -> only digit 0 shows C0; digits 1-3 show FF.
REQ-030 The bench SHALL cover: out1 changed from F9 to 92 during digit 2 SHOW -> the rest of the frame is unchanged; the next frame's digit 1 shows 92.
REQ-031 The bench SHALL cover: enable dropped during digit 2 SHOW -> next cycle an=F, seg=FF, digit_idx=0, no frame_done; re-enabled -> restart at digit 0 BLANK.
REQ-032 The bench SHALL cover: rst_n pulsed low between clock edges during SHOW -> an=F and seg=FF before the next clk edge; all shadows read FF.

Source files
------------

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 4-digit 7-segment scan driver with anti-ghost blanking
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       lz_blank,
  input  logic [7:0] out0,
  input  logic [7:0] out1,
  input  logic [7:0] out2,
  input  logic [7:0] out3,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [7:0]    GLYPH_ZERO = 8'hC0;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    didx_n;

  logic [7:0] sh_code0, sh_code1, sh_code2, sh_code3;
  logic       sh_lz;
  logic       capture;

  logic [7:0] seg_n;
  logic [3:0] an_n;
  logic       frame_done_n;

  logic       blank3, blank2, blank1;
  logic [7:0] disp_code;

  // State, slot counter and digit index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      digit_idx <= 2'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digit_idx <= didx_n;
    end
  end

  // Next-state: one counter spans BLANK then SHOW; dropping enable always returns to IDLE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    didx_n  = digit_idx;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      didx_n  = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          didx_n  = 2'd0;
        end
        BLANK: begin
          cnt_n = cnt + CW'(1);
          if (cnt == BLANK_LAST) state_n = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            didx_n  = digit_idx + 2'd1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          didx_n  = 2'd0;
        end
      endcase
    end
  end

  // Frame snapshot is taken on the edge that enters digit 0's first blank cycle
  assign capture = (state_n == BLANK) && (didx_n == 2'd0) && (cnt_n == '0);

  // Shadow registers hold one frame's worth of codes so a frame never mixes values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_code0 <= 8'hFF;
      sh_code1 <= 8'hFF;
      sh_code2 <= 8'hFF;
      sh_code3 <= 8'hFF;
      sh_lz    <= 1'b0;
    end else if (capture) begin
      sh_code0 <= out0;
      sh_code1 <= out1;
      sh_code2 <= out2;
      sh_code3 <= out3;
      sh_lz    <= lz_blank;
    end
  end

  // Leading-zero suppression cascades from the thousands digit downward; ones digit is never blanked
  always_comb begin
    blank3 = sh_lz && (sh_code3 == GLYPH_ZERO);
    blank2 = blank3 && (sh_code2 == GLYPH_ZERO);
    blank1 = blank2 && (sh_code1 == GLYPH_ZERO);
    case (didx_n)
      2'd0:    disp_code = sh_code0;
      2'd1:    disp_code = blank1 ? 8'hFF : sh_code1;
      2'd2:    disp_code = blank2 ? 8'hFF : sh_code2;
      default: disp_code = blank3 ? 8'hFF : sh_code3;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with the state they describe
  always_comb begin
    an_n         = 4'b1111;
    seg_n        = 8'hFF;
    frame_done_n = 1'b0;
    if (state_n == SHOW) begin
      an_n         = ~(4'b0001 << didx_n);
      seg_n        = disp_code;
      frame_done_n = (didx_n == 2'd3) && (cnt_n == SLOT_LAST);
    end
  end

  // Output register; async reset blanks the display without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       lz_blank;
  logic [7:0] out0, out1, out2, out3;
  logic [7:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_code [4];

  seg_scan_driver #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 8'(an), 8'h0F);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_idx"}, 8'(digit_idx), 8'h00);
    chk({tag, "_fd"}, 8'(frame_done), 8'h00);
  endtask

  // Frame position k: slot = k/8, 2 blank cycles then 6 show cycles, frame_done on k%32 == 31
  task automatic run_cycles(input string tag, input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      int kk, d, p;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      kk = k0 + i;
      d  = (kk / 8) % 4;
      p  = kk % 8;
      e_an  = (p < 2) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = (p < 2) ? 8'hFF : exp_code[d];
      chk($sformatf("%s_an_k%0d", tag, kk), 8'(an), 8'(e_an));
      chk($sformatf("%s_seg_k%0d", tag, kk), seg, e_seg);
      chk($sformatf("%s_idx_k%0d", tag, kk), 8'(digit_idx), 8'(d));
      chk($sformatf("%s_fd_k%0d", tag, kk), 8'(frame_done), 8'((kk % 32) == 31));
      @(negedge clk);
    end
  endtask

  task automatic restart(input string tag);
    enable = 1'b0;
    @(negedge clk);
    chk_dark({tag, "_idle"});
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; lz_blank = 1'b0;
    out0 = 8'hC0; out1 = 8'hF9; out2 = 8'hA4; out3 = 8'hB0;
    @(negedge clk);
    chk_dark("reset");
    chk("reset_sh0", dut.sh_code0, 8'hFF);
    chk("reset_sh3", dut.sh_code3, 8'hFF);

    // Two full frames, plain digits
    exp_code[0] = 8'hC0; exp_code[1] = 8'hF9; exp_code[2] = 8'hA4; exp_code[3] = 8'hB0;
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);
    run_cycles("plain", 0, 64);

    // Leading zeros on digits 3 and 2 blanked, digit 1 shown
    out3 = 8'hC0; out2 = 8'hC0; out1 = 8'hF9; out0 = 8'hC0; lz_blank = 1'b1;
    exp_code[0] = 8'hC0; exp_code[1] = 8'hF9; exp_code[2] = 8'hFF; exp_code[3] = 8'hFF;
    restart("lz2");
    run_cycles("lz2", 0, 32);

    // All zeros: only ones digit lit
    out1 = 8'hC0;
    exp_code[1] = 8'hFF;
    restart("lz3");
    run_cycles("lz3", 0, 32);

    // DP on a zero glyph prevents blanking of that digit
    out3 = 8'h40;
    exp_code[3] = 8'h40; exp_code[2] = 8'hC0; exp_code[1] = 8'hC0;
    restart("lzdp");
    run_cycles("lzdp", 0, 32);

    // Mid-frame input change is deferred to the next frame
    out0 = 8'hC0; out1 = 8'hF9; out2 = 8'hA4; out3 = 8'hB0; lz_blank = 1'b0;
    exp_code[0] = 8'hC0; exp_code[1] = 8'hF9; exp_code[2] = 8'hA4; exp_code[3] = 8'hB0;
    restart("shadow");
    run_cycles("shadow", 0, 20);
    out1 = 8'h92;
    run_cycles("shadow", 20, 12);
    exp_code[1] = 8'h92;
    run_cycles("shadow_next", 0, 32);

    // Enable dropped during digit 2 show
    restart("drop_pre");
    run_cycles("drop", 0, 20);
    enable = 1'b0;
    @(negedge clk);
    chk_dark("drop_idle0");
    @(negedge clk);
    chk_dark("drop_idle1");
    enable = 1'b1;
    @(negedge clk);
    run_cycles("drop_re", 0, 12);

    // Async reset between edges during digit 0 show
    restart("rst_pre");
    run_cycles("rst_pre", 0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_an", 8'(an), 8'h0F);
    chk("rst_async_seg", seg, 8'hFF);
    chk("rst_sh0", dut.sh_code0, 8'hFF);
    chk("rst_sh1", dut.sh_code1, 8'hFF);
    chk("rst_sh2", dut.sh_code2, 8'hFF);
    chk("rst_sh3", dut.sh_code3, 8'hFF);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run_cycles("rst_post", 0, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
